thermostat_ctrl: RTL and testbench
==================================

Name: thermostat_ctrl

Overview:
- Parametrised successor to the Ex8 fixed 5-bit heating/cooling controller.
- Adds configurable temperature width and hysteresis thresholds, and a runtime operating mode (off / heat-only / cool-only / auto).
- Adds minimum-dwell anti-short-cycle timing and a state/status readout.
- Sits between the temperature sensor input bus and the heater/cooler drive outputs; all outputs registered.

Parameters:
TEMP_W, 5, width of unsigned temperature input
HEAT_ON, 18, heating starts when temperature <= HEAT_ON
HEAT_OFF, 20, heating stops when temperature >= HEAT_OFF
COOL_ON, 22, cooling starts when temperature >= COOL_ON
COOL_OFF, 20, cooling stops when temperature <= COOL_OFF
MIN_DWELL, 4, minimum cycles spent in any state before leaving it (>= 1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
temperature  input  TEMP_W  unsigned temperature sample
mode  input  2  00 off, 01 heat-only, 10 cool-only, 11 auto
heating  output  1  heater drive, registered
cooling  output  1  cooler drive, registered
state  output  2  00 IDLE, 01 HEAT, 10 COOL (11 never driven)
dwell_busy  output  1  high while dwell counter non-zero

Behaviour:
- Reset (rst=1 at rising edge):
  - state=IDLE, heating=0, cooling=0, dwell counter=0, dwell_busy=0.
  - Reset overrides all other inputs, including mid-HEAT or mid-COOL.
  - First transition is allowed on the first edge after reset release.
- Legal parameter ordering: HEAT_ON < HEAT_OFF <= COOL_OFF < COOL_ON, all < 2^TEMP_W. Compare with elaboration-time checks.
- All comparisons are unsigned and TEMP_W wide.
- Outputs are decoded from registered state: heating=(state==HEAT), cooling=(state==COOL). Never both high.
- Latency: inputs sampled at edge N; state and outputs reflect the decision from edge N.
- heat_en = mode[0]; cool_en = mode[1].
- IDLE transitions (only when dwell counter==0):
  - If heat_en and temperature <= HEAT_ON -> HEAT.
  - Else if cool_en and temperature >= COOL_ON -> COOL.
  - Otherwise stay in IDLE.
  - Heat has priority if both conditions are true.
- HEAT transitions:
  - If heat_en=0 -> IDLE immediately, ignoring the dwell counter (forced off).
  - Else if dwell counter==0 and temperature >= HEAT_OFF -> IDLE.
- COOL transitions:
  - If cool_en=0 -> IDLE immediately, ignoring the dwell counter.
  - Else if dwell counter==0 and temperature <= COOL_OFF -> IDLE.
- HEAT<->COOL direct transitions are forbidden; a change always passes through IDLE.
- Dwell counter:
  - Width is clog2(MIN_DWELL+1).
  - On any edge where state changes (including forced-off), load MIN_DWELL-1.
  - Otherwise decrement if non-zero, saturating at 0.
  - Result: every state entered is held for at least MIN_DWELL cycles, except forced-off exits from HEAT/COOL.
  - Forced-off still loads the counter, so the IDLE off-time lockout applies.
- MIN_DWELL=1 gives no dwell restriction, which matches the original Ex8 hysteresis behaviour.
- dwell_busy = (counter != 0), registered.
- Temperature at 0 or 2^TEMP_W-1 needs no special handling: there is no wrap and no arithmetic on temperature.
- Mode change while in IDLE takes effect on the next edge, subject to the dwell counter.

Test Plan:
- Reset: hold rst for 2 cycles with temperature=10, mode=11 -> heating=0, cooling=0, state=00, dwell_busy=0; first edge after release -> state=01, heating=1.
- Heat hysteresis (MIN_DWELL=1, mode=11): ramp temperature 25→10→25 by 1 per cycle -> cooling high from 22 down to 20 (drops at 20); heating rises at 18 falling, stays high through 19, drops at 20 rising; both never high together.
- Dwell lockout (default MIN_DWELL=4): temperature=15 enters HEAT at edge E; set temperature=25 at E+1 -> heating stays 1 through E+3, drops at E+4; COOL is not entered until IDLE has held 4 cycles (edge E+8).
- Mode gating: mode=01, temperature=30 -> cooling stays 0 indefinitely; mode=10, temperature=5 -> heating stays 0; mode=00 -> state stays 00.
- Forced off: in HEAT one cycle after entry (dwell_busy=1), set mode=00 -> heating=0 on next edge, dwell_busy=1 for 3 further cycles; re-enabling mode=11 with temperature=10 re-enters HEAT only once dwell_busy=0.
- Reset mid-operation: assert rst for 1 cycle while in COOL with dwell_busy=1 -> state=00, cooling=0, dwell_busy=0 on that edge; with temperature=30 held, COOL re-entered on the first edge after release.

Source files
------------

// File: rtl/thermostat_ctrl.sv
// Heating/cooling controller with hysteresis thresholds, runtime mode gating
// and a minimum-dwell anti-short-cycle timer. All outputs are registered.
module thermostat_ctrl #(
    parameter int unsigned TEMP_W    = 5,
    parameter int unsigned HEAT_ON   = 18,
    parameter int unsigned HEAT_OFF  = 20,
    parameter int unsigned COOL_ON   = 22,
    parameter int unsigned COOL_OFF  = 20,
    parameter int unsigned MIN_DWELL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TEMP_W-1:0] temperature,
    input  logic [1:0]        mode,
    output logic              heating,
    output logic              cooling,
    output logic [1:0]        state,
    output logic              dwell_busy
);

    localparam int unsigned DWELL_W = $clog2(MIN_DWELL + 1);

    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(MIN_DWELL - 1);
    localparam logic [TEMP_W-1:0]  HEAT_ON_T  = TEMP_W'(HEAT_ON);
    localparam logic [TEMP_W-1:0]  HEAT_OFF_T = TEMP_W'(HEAT_OFF);
    localparam logic [TEMP_W-1:0]  COOL_ON_T  = TEMP_W'(COOL_ON);
    localparam logic [TEMP_W-1:0]  COOL_OFF_T = TEMP_W'(COOL_OFF);

    // Reject parameter sets that would break the hysteresis ordering.
    if (MIN_DWELL < 1) begin : g_bad_dwell
        $error("thermostat_ctrl: MIN_DWELL must be >= 1");
    end
    if (!(HEAT_ON < HEAT_OFF)) begin : g_bad_heat
        $error("thermostat_ctrl: HEAT_ON must be below HEAT_OFF");
    end
    if (!(HEAT_OFF <= COOL_OFF)) begin : g_bad_band
        $error("thermostat_ctrl: HEAT_OFF must not exceed COOL_OFF");
    end
    if (!(COOL_OFF < COOL_ON)) begin : g_bad_cool
        $error("thermostat_ctrl: COOL_OFF must be below COOL_ON");
    end
    if ((TEMP_W < 32) && (64'(COOL_ON) >= (64'd1 << TEMP_W))) begin : g_bad_range
        $error("thermostat_ctrl: thresholds must fit in TEMP_W bits");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HEAT = 2'b01,
        ST_COOL = 2'b10
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [DWELL_W-1:0]   dwell_q;
    logic [DWELL_W-1:0]   dwell_d;
    logic                 heating_d;
    logic                 cooling_d;
    logic                 dwell_busy_d;
    logic                 heat_en;
    logic                 cool_en;

    assign heat_en = mode[0];
    assign cool_en = mode[1];
    assign state   = state_q;

    // State, dwell timer and decoded outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dwell_q    <= '0;
            heating    <= 1'b0;
            cooling    <= 1'b0;
            dwell_busy <= 1'b0;
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            heating    <= heating_d;
            cooling    <= cooling_d;
            dwell_busy <= dwell_busy_d;
        end
    end

    // Next-state decision, dwell reload on every change, output decode.
    always_comb begin
        state_d      = state_q;
        dwell_d      = dwell_q;
        heating_d    = 1'b0;
        cooling_d    = 1'b0;
        dwell_busy_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dwell_q == '0) begin
                    if (heat_en && (temperature <= HEAT_ON_T)) begin
                        state_d = ST_HEAT;
                    end else if (cool_en && (temperature >= COOL_ON_T)) begin
                        state_d = ST_COOL;
                    end
                end
            end
            ST_HEAT: begin
                // Disabling heat drops out at once; the dwell only guards
                // thermostatic exits.
                if (!heat_en) begin
                    state_d = ST_IDLE;
                end else if ((dwell_q == '0) && (temperature >= HEAT_OFF_T)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_COOL: begin
                if (!cool_en) begin
                    state_d = ST_IDLE;
                end else if ((dwell_q == '0) && (temperature <= COOL_OFF_T)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Forced exits also reload, so IDLE lockout always follows an exit.
        if (state_d != state_q) begin
            dwell_d = DWELL_LOAD;
        end else if (dwell_q != '0) begin
            dwell_d = dwell_q - DWELL_W'(1);
        end

        heating_d    = (state_d == ST_HEAT);
        cooling_d    = (state_d == ST_COOL);
        dwell_busy_d = (dwell_d != '0);
    end

endmodule

// File: tb/tb_thermostat_ctrl.sv
// Directed bench for thermostat_ctrl: a default-dwell instance for dwell,
// mode and reset behaviour, and a MIN_DWELL=1 instance for the pure
// hysteresis ramp.
module tb_thermostat_ctrl;

    logic       clk;
    logic       rst0, rst1;
    logic [4:0] temp0, temp1;
    logic [1:0] mode0, mode1;
    logic       heat0, cool0, busy0;
    logic       heat1, cool1, busy1;
    logic [1:0] st0, st1;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    typedef struct {
        bit         sel;
        logic       h;
        logic       c;
        logic [1:0] s;
        logic       b;
        string      tag;
    } exp_t;

    exp_t sb[$];

    thermostat_ctrl dut (
        .clk         (clk),
        .rst         (rst0),
        .temperature (temp0),
        .mode        (mode0),
        .heating     (heat0),
        .cooling     (cool0),
        .state       (st0),
        .dwell_busy  (busy0)
    );

    thermostat_ctrl #(.MIN_DWELL(1)) dut1 (
        .clk         (clk),
        .rst         (rst1),
        .temperature (temp1),
        .mode        (mode1),
        .heating     (heat1),
        .cooling     (cool1),
        .state       (st1),
        .dwell_busy  (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exclusivity and encoding invariants on both instances every cycle.
    always @(negedge clk) begin
        if (armed) begin
            checks++;
            assert (!(heat0 && cool0) && !(heat1 && cool1) && (st0 !== 2'b11) && (st1 !== 2'b11))
            else begin
                errors++;
                $error("FAIL invariant h0=%b c0=%b s0=%b h1=%b c1=%b s1=%b",
                       heat0, cool0, st0, heat1, cool1, st1);
            end
        end
    end

    // Drive one cycle of stimulus, queue the expectation, compare after the edge.
    task automatic step(input bit sel, input logic r, input logic [4:0] t,
                        input logic [1:0] m, input logic eh, input logic ec,
                        input logic [1:0] es, input logic eb, input string tag);
        exp_t e;
        exp_t g;
        logic [4:0] obs;
        logic [4:0] req;
        if (sel == 1'b0) begin
            rst0 = r; temp0 = t; mode0 = m;
        end else begin
            rst1 = r; temp1 = t; mode1 = m;
        end
        e.sel = sel; e.h = eh; e.c = ec; e.s = es; e.b = eb; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        obs = g.sel ? {heat1, cool1, st1, busy1} : {heat0, cool0, st0, busy0};
        req = {g.h, g.c, g.s, g.b};
        checks++;
        assert (obs === req)
        else begin
            errors++;
            $error("FAIL %s got h/c/s/b=%b/%b/%b/%b expected %b/%b/%b/%b",
                   g.tag, obs[4], obs[3], obs[2:1], obs[0],
                   req[4], req[3], req[2:1], req[0]);
        end
    endtask

    // Plain hysteresis reference for the no-dwell instance in auto mode.
    function automatic logic [1:0] hyst_next(input logic [1:0] s, input int t);
        logic [1:0] n;
        n = s;
        case (s)
            2'b00: if (t <= 18) n = 2'b01; else if (t >= 22) n = 2'b10;
            2'b01: if (t >= 20) n = 2'b00;
            2'b10: if (t <= 20) n = 2'b00;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    initial begin
        logic [1:0] ms;
        int ramp[$];

        rst0 = 1'b1; temp0 = 5'd10; mode0 = 2'b11;
        rst1 = 1'b1; temp1 = 5'd25; mode1 = 2'b11;

        // Hysteresis ramp 25 -> 10 -> 25 with no dwell restriction.
        step(1, 1, 25, 3, 0, 0, 2'd0, 0, "ramp_reset");
        armed = 1'b1;
        for (int t = 25; t >= 10; t--) ramp.push_back(t);
        for (int t = 11; t <= 25; t++) ramp.push_back(t);
        ms = 2'b00;
        foreach (ramp[i]) begin
            ms = hyst_next(ms, ramp[i]);
            step(1, 0, 5'(ramp[i]), 3, ms == 2'b01, ms == 2'b10, ms, 0,
                 $sformatf("ramp_t%0d_i%0d", ramp[i], i));
        end
        rst1 = 1'b1;

        // Reset held two cycles, then immediate heat entry.
        step(0, 1, 10, 3, 0, 0, 2'd0, 0, "reset_a");
        step(0, 1, 10, 3, 0, 0, 2'd0, 0, "reset_b");
        step(0, 0, 10, 3, 1, 0, 2'd1, 1, "first_heat");

        // Dwell lockout: heat held to E+4, cool not before E+8.
        step(0, 0, 25, 3, 1, 0, 2'd1, 1, "dwell_e1");
        step(0, 0, 25, 3, 1, 0, 2'd1, 1, "dwell_e2");
        step(0, 0, 25, 3, 1, 0, 2'd1, 0, "dwell_e3");
        step(0, 0, 25, 3, 0, 0, 2'd0, 1, "heat_off_e4");
        step(0, 0, 25, 3, 0, 0, 2'd0, 1, "idle_e5");
        step(0, 0, 25, 3, 0, 0, 2'd0, 1, "idle_e6");
        step(0, 0, 25, 3, 0, 0, 2'd0, 0, "idle_e7");
        step(0, 0, 25, 3, 0, 1, 2'd2, 1, "cool_e8");

        // Reset in COOL with dwell pending, then immediate re-entry.
        step(0, 1, 30, 3, 0, 0, 2'd0, 0, "rst_in_cool");
        step(0, 0, 30, 3, 0, 1, 2'd2, 1, "cool_reenter");

        // Mode gating: heat-only forces COOL off and never cools.
        step(0, 0, 30, 1, 0, 0, 2'd0, 1, "cool_forced_off");
        for (int i = 0; i < 6; i++)
            step(0, 0, 30, 1, 0, 0, 2'd0, logic'(i < 2), $sformatf("heat_only_%0d", i));
        for (int i = 0; i < 3; i++)
            step(0, 0, 5, 2, 0, 0, 2'd0, 0, $sformatf("cool_only_%0d", i));
        step(0, 0, 10, 0, 0, 0, 2'd0, 0, "mode_off_cold_a");
        step(0, 0, 10, 0, 0, 0, 2'd0, 0, "mode_off_cold_b");
        step(0, 0, 30, 0, 0, 0, 2'd0, 0, "mode_off_hot");

        // Forced off from HEAT still imposes the IDLE lockout.
        step(0, 0, 10, 3, 1, 0, 2'd1, 1, "fo_enter");
        step(0, 0, 10, 3, 1, 0, 2'd1, 1, "fo_busy");
        step(0, 0, 10, 0, 0, 0, 2'd0, 1, "fo_off");
        step(0, 0, 10, 3, 0, 0, 2'd0, 1, "fo_lock1");
        step(0, 0, 10, 3, 0, 0, 2'd0, 1, "fo_lock2");
        step(0, 0, 10, 3, 0, 0, 2'd0, 0, "fo_lock3");
        step(0, 0, 10, 3, 1, 0, 2'd1, 1, "fo_reenter");

        // Reset in HEAT, then threshold boundaries around the dead band.
        step(0, 1, 10, 3, 0, 0, 2'd0, 0, "rst_in_heat");
        step(0, 0, 20, 3, 0, 0, 2'd0, 0, "idle_at_20");
        step(0, 0, 21, 3, 0, 0, 2'd0, 0, "idle_at_21");
        step(0, 0, 22, 3, 0, 1, 2'd2, 1, "cool_at_22");
        step(0, 0, 21, 3, 0, 1, 2'd2, 1, "cool_hold_a");
        step(0, 0, 21, 3, 0, 1, 2'd2, 1, "cool_hold_b");
        step(0, 0, 21, 3, 0, 1, 2'd2, 0, "cool_hold_c");
        step(0, 0, 20, 3, 0, 0, 2'd0, 1, "cool_off_at_20");

        // Extremes of the temperature range.
        step(0, 1, 0, 3, 0, 0, 2'd0, 0, "rst_ext");
        step(0, 0, 0, 3, 1, 0, 2'd1, 1, "heat_at_0");
        step(0, 1, 31, 3, 0, 0, 2'd0, 0, "rst_ext2");
        step(0, 0, 31, 3, 0, 1, 2'd2, 1, "cool_at_31");

        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
        end

        armed = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
